// File: rtl/relu_maxpool2x2.sv
// Streaming ReLU followed by 2x2 stride-2 max pooling over a raster-order fp32 stream.
// Pair maxima from even rows wait in a half-width line buffer for the matching odd row.
module relu_maxpool2x2 #(
  parameter int IN_WIDTH  = 6,
  parameter int IN_HEIGHT = 6
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_in,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        frame_done
);

  localparam int CW    = (IN_WIDTH  > 2) ? $clog2(IN_WIDTH)  : 1;
  localparam int RW    = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
  localparam int HALF  = IN_WIDTH / 2;
  localparam int AW    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam bit H_ODD = (IN_HEIGHT % 2) == 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [31:0]   hreg;
  logic [31:0]   linebuf [0:HALF-1];

  logic [31:0]   r;
  logic [31:0]   hmax;
  logic [31:0]   lb_rd;
  logic [31:0]   pooled;
  logic [AW-1:0] pidx;
  logic          last_col;
  logic          last_row;
  logic          lb_we;

  // After ReLU every value has a clear sign bit, so a 31-bit unsigned
  // compare orders them correctly (Inf/NaN win by bit pattern).
  always_comb begin
    r        = data_in[31] ? '0 : data_in;
    hmax     = (r[30:0] > hreg[30:0]) ? r : hreg;
    pidx     = AW'(col >> 1);
    lb_rd    = linebuf[pidx];
    pooled   = (hmax[30:0] > lb_rd[30:0]) ? hmax : lb_rd;
    last_col = (col == CW'(IN_WIDTH - 1));
    last_row = (row == RW'(IN_HEIGHT - 1));
    lb_we    = valid_in && col[0] && !row[0] && !(H_ODD && last_row);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col        <= '0;
      row        <= '0;
      hreg       <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      frame_done <= 1'b0;
      if (valid_in) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        frame_done <= last_col && last_row;
        if (!col[0]) begin
          hreg <= r;
        end else if (row[0]) begin
          data_out  <= pooled;
          valid_out <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) linebuf[pidx] <= hmax;
  end

endmodule

// File: doc/relu_maxpool2x2.md
# relu_maxpool2x2

Streaming ReLU plus 2×2 stride-2 max-pooling stage that sits directly downstream of the 8-channel 3×3 conv filter. It consumes the filter's fp32 output stream (`data_out_conv`/`valid_out`) in raster order and emits one pooled fp32 value per 2×2 window. A half-width line buffer holds horizontal pair maxima from even rows. There is no backpressure: the block accepts one sample per cycle whenever `valid_in` is high.

## Interface
Parameters:
- IN_WIDTH, 6, columns of the incoming feature map (conv output width = image WIDTH-2); must be ≥2
- IN_HEIGHT, 6, rows of the incoming feature map; must be ≥2

Ports:
- clk  input  1  clock, all state updates on rising edge
- resetn  input  1  asynchronous, active-low reset
- valid_in  input  1  `data_in` is valid this cycle; gaps of any length allowed
- data_in  input  32  IEEE-754 single-precision conv result
- data_out  output  32  pooled, ReLU'd fp32 value
- valid_out  output  1  one-cycle strobe qualifying `data_out`
- frame_done  output  1  one-cycle pulse after the last sample of a frame is accepted

## Operation
- **ReLU:** `r = data_in[31] ? 32'h0 : data_in`. Negative values, including -0.0 (0x80000000), become +0.0.
  - All values after ReLU are non-negative, so max comparisons are 31-bit unsigned compares of `r[30:0]`.
  - +Inf and +NaN pass through and win compares by bit pattern. No NaN canonicalisation.
- **Counters:** `col` (0..IN_WIDTH-1) and `row` (0..IN_HEIGHT-1) advance only on `valid_in`.
  - `col` wraps to 0 after IN_WIDTH-1, then `row` increments.
  - `row` wraps to 0 after IN_HEIGHT-1, so the next frame starts at (0,0).
- **Even col (col[0]=0):** `hreg <= r`.
- **Odd col:** `hmax = max(hreg, r)`.
  - Even row: `linebuf[col>>1] <= hmax`.
  - Odd row: `data_out <= max(linebuf[col>>1], hmax)`, `valid_out <= 1`.
- **Odd IN_WIDTH:** the last column is accepted and counted but never pooled.
- **Odd IN_HEIGHT:** the last row is accepted and counted but produces no output and never reaches `linebuf`.
- **Output count per frame:** floor(IN_WIDTH/2) × floor(IN_HEIGHT/2), in raster order of the pooled map.
- **linebuf:** floor(IN_WIDTH/2) × 32 bits, no reset required. Every entry is written on an even row before it is read on the following odd row.

## Timing
- **Reset values:** `data_out` = 0, `valid_out` = 0, `frame_done` = 0, `col` = `row` = 0, `hreg` = 0.
- **Latency:** 1 cycle. `valid_out` is high the cycle after the `valid_in` that accepts an odd-row, odd-col sample.
- **valid_out:** low in every other cycle. `data_out` holds its last value while `valid_out` is low.
- **Throughput:** 1 sample/cycle sustained. Consecutive outputs in the same pooled row are ≥2 cycles apart.
- **frame_done:** high the cycle after the `valid_in` accepting (IN_HEIGHT-1, IN_WIDTH-1).
  - It coincides with the final `valid_out` when both dimensions are even.
- **Back-to-back frames:** the first sample of frame n+1 may arrive the cycle after the last sample of frame n, with no bubble.
- **Reset mid-frame:** counters return to 0 and any partial window is discarded. The first `valid_in` after `resetn` deasserts is pixel (0,0).
- **valid_in low:** no state changes except `valid_out`/`frame_done` returning to 0.

## Test plan
- **Ascending 4×4 frame** (IN_WIDTH=IN_HEIGHT=4): values 1.0..16.0 raster, continuous `valid_in` -> outputs 0x40C00000 (6.0), 0x41000000 (8.0), 0x41600000 (14.0), 0x41800000 (16.0). Each arrives 1 cycle after its sample; `frame_done` is on the cycle of the last output.
- **All-negative 4×4 frame:** -1.0 (0xBF800000), plus one -0.0 -> four outputs, all 0x00000000.
- **Odd 5×5 frame** (IN_WIDTH=IN_HEIGHT=5): values 1..25 -> exactly 4 outputs: 7.0, 9.0, 17.0, 19.0. `frame_done` one cycle after sample 25, with no output on that cycle.
- **Gapped input:** the 4×4 ascending frame with `valid_in` toggling 1-0-0-1 randomly -> identical output values in identical order; each output 1 cycle after its odd/odd sample.
- **Reset mid-frame:** assert `resetn` low after 6 samples, then send a full 4×4 frame of 2.0 -> four outputs of 0x40000000 only; no stale window values.
- **Back-to-back frames, default 6×6:** two frames with no gap, the second being the first negated -> 9 correct maxima, then 9 zeros. Two `frame_done` pulses, 36 cycles apart.
